mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between two requesters: the core port (fetch/load/store, driven from the multicycle control unit's mem_read/mem_write) and the DMA/debug port.
- Latches the winning request, runs a valid/ready transaction with wait states and a timeout, then returns a one-cycle completion pulse to the owner.
- Sits between the control unit/datapath and the memory model.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (core/DMA) arbiter for the single-port unified memory
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_WAIT     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_be,
    output logic                cpu_gnt,
    output logic                cpu_done,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_err,
    input  logic                dma_req,
    input  logic                dma_we,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic [DATA_W-1:0]   dma_wdata,
    input  logic [DATA_W/8-1:0] dma_be,
    output logic                dma_gnt,
    output logic                dma_done,
    output logic [DATA_W-1:0]   dma_rdata,
    output logic                dma_err,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WW-1:0] LAST_WAIT  = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          r_state;
    logic            r_owner_dma;
    logic [WW-1:0]   r_wait_cnt;
    logic [SW-1:0]   r_starve_cnt;

    logic            w_dma_wins;
    logic            w_timeout;
    logic [DATA_W-1:0] w_rdata;

    assign w_dma_wins = dma_req && (!cpu_req || (r_starve_cnt == STARVE_MAX));
    assign w_timeout  = (MAX_WAIT > 0) && (r_wait_cnt == LAST_WAIT);
    // Writes return zero data so the owner never sees stale bus contents.
    assign w_rdata    = mem_we ? '0 : mem_rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner_dma  <= 1'b0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            cpu_gnt      <= 1'b0;
            cpu_done     <= 1'b0;
            cpu_rdata    <= '0;
            cpu_err      <= 1'b0;
            dma_gnt      <= 1'b0;
            dma_done     <= 1'b0;
            dma_rdata    <= '0;
            dma_err      <= 1'b0;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        r_state     <= ACCESS;
                        busy        <= 1'b1;
                        mem_valid   <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_owner_dma <= w_dma_wins;
                        if (w_dma_wins) begin
                            dma_gnt      <= 1'b1;
                            mem_we       <= dma_we;
                            mem_addr     <= dma_addr;
                            mem_wdata    <= dma_wdata;
                            mem_be       <= dma_be;
                            r_starve_cnt <= '0;
                        end else begin
                            cpu_gnt   <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_be    <= cpu_be;
                            if (!dma_req)
                                r_starve_cnt <= '0;
                            else if (r_starve_cnt != STARVE_MAX)
                                r_starve_cnt <= r_starve_cnt + SW'(1);
                        end
                    end
                end
                ACCESS: begin
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                    // A ready arriving on the timeout edge still completes the access.
                    if (mem_ready || w_timeout) begin
                        r_state   <= RESP;
                        mem_valid <= 1'b0;
                        if (r_owner_dma) begin
                            dma_done  <= 1'b1;
                            dma_rdata <= mem_ready ? w_rdata : '0;
                            dma_err   <= !mem_ready;
                        end else begin
                            cpu_done  <= 1'b1;
                            cpu_rdata <= mem_ready ? w_rdata : '0;
                            cpu_err   <= !mem_ready;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    busy       <= 1'b0;
                    r_wait_cnt <= '0;
                    cpu_done   <= 1'b0;
                    cpu_rdata  <= '0;
                    cpu_err    <= 1'b0;
                    dma_done   <= 1'b0;
                    dma_rdata  <= '0;
                    dma_err    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [3:0]  cpu_be, dma_be;
    logic        cpu_gnt, cpu_done, cpu_err, dma_gnt, dma_done, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_valid, mem_we, mem_ready, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        logic        is_dma;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_be(dma_be), .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .dma_err(dma_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push(input logic is_dma, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_dma = is_dma;
        e.rdata  = rdata;
        e.err    = err;
        sb.push_back(e);
    endtask

    task automatic check_done();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk("done_port", {62'd0, dma_done, cpu_done}, e.is_dma ? 64'd2 : 64'd1);
            chk("done_rdata", 64'(e.is_dma ? dma_rdata : cpu_rdata), 64'(e.rdata));
            chk("done_err", 64'(e.is_dma ? dma_err : cpu_err), 64'(e.err));
            chk("other_port_rdata", 64'(e.is_dma ? cpu_rdata : dma_rdata), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] exp_owner [6];
        logic [2:0] exp_starve [6];
        exp_owner  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        exp_starve = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_be = 0;
        mem_ready = 0; mem_rdata = 0;
        #1 reset = 1;
        @(negedge clock);
        chk("reset_flags", 64'({cpu_gnt, cpu_done, cpu_err, dma_gnt, dma_done, dma_err,
                               mem_valid, mem_we, busy}), 64'd0);
        chk("reset_data", 64'(mem_addr | mem_wdata | cpu_rdata | dma_rdata | 32'(mem_be)), 64'd0);
        reset = 0;
        cyc();

        // Core read, zero wait states
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_be = 4'hF;
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        push(1'b0, 32'hDEADBEEF, 1'b0);
        cyc();
        chk("t1_gnt", {62'd0, dma_gnt, cpu_gnt}, 64'd1);
        chk("t1_valid_busy", {62'd0, mem_valid, busy}, 64'd3);
        chk("t1_addr", 64'(mem_addr), 64'h40);
        cpu_req = 0;
        cyc();
        check_done();
        chk("t1_c2_valid_busy_gnt", {61'd0, mem_valid, busy, cpu_gnt}, 64'd2);
        mem_ready = 0;
        cyc();
        chk("t1_c3_idle", {62'd0, busy, cpu_done}, 64'd0);

        // DMA write with three wait states
        dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'h12345678; dma_be = 4'h3;
        push(1'b1, 32'h0, 1'b0);
        cyc();
        chk("t2_gnt", {62'd0, dma_gnt, cpu_gnt}, 64'd2);
        dma_req = 0; dma_addr = 32'hFFFF; dma_wdata = 0; dma_be = 0; dma_we = 0;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_valid", 64'(mem_valid), 64'd1);
            chk("t2_fields", {27'd0, mem_we, mem_be, mem_addr}, {27'd0, 1'b1, 4'h3, 32'h100});
            chk("t2_wdata", 64'(mem_wdata), 64'h12345678);
            chk("t2_cpu_quiet", 64'({cpu_gnt, cpu_done, cpu_err}), 64'd0);
            if (k == 4) begin
                mem_ready = 1;
                mem_rdata = 32'hAAAA5555;
            end
            cyc();
        end
        check_done();
        chk("t2_cpu_done", 64'(cpu_done), 64'd0);
        mem_ready = 0;
        cyc();
        chk("t2_idle", 64'(busy), 64'd0);

        // Both ports requesting continuously: starvation guard
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        dma_req = 1; dma_we = 0; dma_addr = 32'h180;
        mem_ready = 1;
        for (int g = 0; g < 6; g++) begin
            push(exp_owner[g] == 2'b10, 32'h1000_0000 + 32'(g), 1'b0);
            mem_rdata = 32'h1000_0000 + 32'(g);
            n = 0;
            while (!(cpu_gnt || dma_gnt) && n < 10) begin
                cyc();
                n++;
            end
            chk("t3_gnt_seen", 64'(n < 10), 64'd1);
            chk("t3_owner", {62'd0, dma_gnt, cpu_gnt}, 64'(exp_owner[g]));
            chk("t3_starve", 64'(dut.r_starve_cnt), 64'(exp_starve[g]));
            if (g == 5) begin
                cpu_req = 0;
                dma_req = 0;
            end
            cyc();
            check_done();
        end
        mem_ready = 0;
        cyc();
        chk("t3_idle", 64'(busy), 64'd0);

        // Timeout: no ready for the full window
        cpu_req = 1; cpu_addr = 32'h200; mem_rdata = 32'hFFFFFFFF;
        push(1'b0, 32'h0, 1'b1);
        cyc();
        cpu_req = 0;
        n = 0;
        while (mem_valid && n < 40) begin
            n++;
            cyc();
        end
        chk("t4_valid_cycles", 64'(n), 64'd15);
        check_done();
        cyc();
        chk("t4_idle", 64'({busy, cpu_done}), 64'd0);

        // Ready on the last allowed ACCESS cycle wins over timeout
        cpu_req = 1; cpu_addr = 32'h204;
        push(1'b0, 32'hCAFEF00D, 1'b0);
        cyc();
        cpu_req = 0;
        for (int k = 1; k <= 14; k++) begin
            chk("t5_valid", 64'(mem_valid), 64'd1);
            cyc();
        end
        chk("t5_valid_last", 64'(mem_valid), 64'd1);
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        cyc();
        check_done();
        mem_ready = 0;
        cyc();

        // Reset in the middle of ACCESS
        cpu_req = 1; cpu_addr = 32'h300;
        cyc();
        chk("t6_gnt_before", 64'(cpu_gnt), 64'd1);
        cpu_req = 0;
        reset = 1;
        #1;
        chk("t6_async_drop", 64'({mem_valid, busy, cpu_gnt}), 64'd0);
        mem_ready = 1;
        cyc();
        cyc();
        reset = 0;
        mem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            chk("t6_no_done", 64'({cpu_done, busy}), 64'd0);
            cyc();
        end
        cpu_req = 1; cpu_addr = 32'h304; mem_ready = 1; mem_rdata = 32'h0BADF00D;
        push(1'b0, 32'h0BADF00D, 1'b0);
        cyc();
        chk("t6_regnt", 64'(cpu_gnt), 64'd1);
        cpu_req = 0;
        cyc();
        check_done();
        mem_ready = 0;
        cyc();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
